uc_multiciclo: RTL and testbench

//  Multicycle control unit: sequences the CPU datapath through FETCH/DECODE/EXEC

---
 rtl/uc_multiciclo.sv | 157 +++++++++++++++
 tb/tb_uc_multiciclo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// ---------------------------------------------------------------------------
// uc_multiciclo
//   Multicycle control unit. Each instruction walks FETCH -> DECODE -> EXEC.
//   FETCH waits on the program-memory ready handshake and loads the
//   instruction register. DECODE gives the IR one cycle to settle. EXEC
//   drives the register-file, flag, ALU and PC controls for one cycle.
//   A fetch that waits too long for mem_ready drops the unit into a
//   sticky FAULT state, which only reset can clear.
//
// Parameters
//   TIMEOUT  max cycles FETCH waits for mem_ready (while run=1) before FAULT
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   run        1 = allow new fetches, 0 = idle in FETCH
//   mem_ready  program memory presents a valid instruction this cycle
//   opcode     opcode field of the instruction register
//   z          zero flag from the flag register
//   mem_req    request instruction at current PC
//   ir_we      load instruction register
//   pc_we      update PC
//   s_inc      PC source: 1 = PC+1, 0 = jump target
//   s_inm      register-file write data from immediate
//   we3        register-file write enable
//   wez        zero-flag write enable
//   op_alu     ALU operation
//   retired    number of completed EXEC cycles (wraps)
//   fault      sticky fetch-timeout indicator
// ---------------------------------------------------------------------------
module uc_multiciclo #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             mem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Last wait-counter value that may still be spent waiting in FETCH.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    mem_req   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    op_alu    = 3'b000;

    case (state_q)
      ST_FETCH: begin
        // Idle (run=0) keeps the wait counter at zero so time spent
        // paused never counts toward the timeout.
        wait_d = '0;
        if (run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            // Ready wins even on the last allowed wait cycle.
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        pc_we     = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = ST_FETCH;
        casez (opcode)
          6'b0?????: begin          // ALU register op, updates zero flag
            we3    = 1'b1;
            wez    = 1'b1;
            op_alu = opcode[4:2];
          end
          6'b10????: begin          // load immediate
            we3   = 1'b1;
            s_inm = 1'b1;
          end
          6'b110???: begin          // unconditional jump
            s_inc = 1'b0;
          end
          6'b1110??: begin          // jump if z=1
            s_inc = ~z;
          end
          default: begin            // 1111??: jump if z=0
            s_inc = z;
          end
        endcase
      end

      default: begin                // ST_FAULT: parked until reset
        fault_d = 1'b1;
      end
    endcase
  end

  assign retired = retired_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_uc_multiciclo
//   Directed bench for uc_multiciclo (TIMEOUT=16, CNT_W=4 so the retired
//   counter wraps within a short run). Control outputs are packed into one
//   vector {mem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, op_alu} and
//   compared against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset, run, mem_ready, z;
  logic [5:0] opcode;
  logic       mem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, fault;
  logic [2:0] op_alu;
  logic [3:0] retired;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_ret = 4'd0;

  wire [9:0] ctrl = {mem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, op_alu};

  // Expected control vectors
  localparam logic [9:0] V_IDLE   = 10'b0_0_0_1_0_0_0_000; // defaults
  localparam logic [9:0] V_FETCHR = 10'b1_1_0_1_0_0_0_000; // run, ready
  localparam logic [9:0] V_FETCHW = 10'b1_0_0_1_0_0_0_000; // run, waiting
  localparam logic [9:0] V_ALU010 = 10'b0_0_1_1_0_1_1_010;
  localparam logic [9:0] V_ALU111 = 10'b0_0_1_1_0_1_1_111;
  localparam logic [9:0] V_LDI    = 10'b0_0_1_1_1_1_0_000;
  localparam logic [9:0] V_JMP    = 10'b0_0_1_0_0_0_0_000;
  localparam logic [9:0] V_NOJMP  = 10'b0_0_1_1_0_0_0_000;

  uc_multiciclo #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .z         (z),
    .mem_req   (mem_req),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .we3       (we3),
    .wez       (wez),
    .op_alu    (op_alu),
    .retired   (retired),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction starting in FETCH with run=1, mem_ready=1.
  task automatic do_instr(input string name, input logic [5:0] op, input logic zv,
                          input logic [9:0] exp_exec, input bit drop_run);
    opcode = op;
    z      = zv;
    #1;
    check_val({name, " fetch"}, 32'(ctrl), 32'(V_FETCHR));
    tick();
    if (drop_run) run = 1'b0;
    #1;
    check_val({name, " decode"}, 32'(ctrl), 32'(V_IDLE));
    tick();
    check_val({name, " exec"}, 32'(ctrl), 32'(exp_exec));
    tick();
    exp_ret = exp_ret + 4'd1;
    check_val({name, " retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; z = 1'b0; opcode = 6'b0;
    tick(); tick();
    check_val("reset ctrl", 32'(ctrl), 32'(V_IDLE));
    check_val("reset retired", 32'(retired), 32'd0);
    check_val("reset fault", 32'(fault), 32'd0);

    // 1: back-to-back ALU instructions, 3 cycles each
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_instr("alu", 6'b001000, 1'b0, V_ALU010, 1'b0);
    check_val("3 retired in 9", 32'(retired), 32'd3);

    // 2: immediate load, unconditional jump, ALU op field boundary
    do_instr("ldi", 6'b100000, 1'b0, V_LDI, 1'b0);
    do_instr("jmp", 6'b110000, 1'b1, V_JMP, 1'b0);
    do_instr("alu111", 6'b011111, 1'b0, V_ALU111, 1'b0);

    // 3: conditional jumps on both flag values
    do_instr("jz z1", 6'b111000, 1'b1, V_JMP, 1'b0);
    do_instr("jz z0", 6'b111000, 1'b0, V_NOJMP, 1'b0);
    do_instr("jnz z0", 6'b111100, 1'b0, V_JMP, 1'b0);
    do_instr("jnz z1", 6'b111111, 1'b1, V_NOJMP, 1'b0);

    // 4a: fetch timeout after 16 waiting cycles
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("wait %0d ctrl", i), 32'(ctrl), 32'(V_FETCHW));
      check_val($sformatf("wait %0d fault", i), 32'(fault), 32'd0);
      tick();
    end
    check_val("timeout fault", 32'(fault), 32'd1);
    check_val("timeout ctrl", 32'(ctrl), 32'(10'b0_0_0_1_0_0_0_000));
    mem_ready = 1'b1;
    tick(); tick();
    check_val("fault sticky", 32'(fault), 32'd1);
    check_val("fault no req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ret = 4'd0;
    check_val("fault cleared", 32'(fault), 32'd0);
    check_val("fault reset retired", 32'(retired), 32'd0);

    // 4b: ready on the 16th (last) waiting cycle wins
    mem_ready = 1'b0;
    opcode = 6'b001000;
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    #1;
    check_val("last-cycle ready", 32'(ctrl), 32'(V_FETCHR));
    tick();
    check_val("last-cycle decode", 32'(ctrl), 32'(V_IDLE));
    check_val("last-cycle fault", 32'(fault), 32'd0);
    tick();
    check_val("last-cycle exec", 32'(ctrl), 32'(V_ALU010));
    tick();
    exp_ret = exp_ret + 4'd1;
    check_val("last-cycle retired", 32'(retired), 32'(exp_ret));

    // 5: long idle with run=0 (mem_ready toggling is ignored), no timeout
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      check_val($sformatf("idle %0d", i), 32'({ctrl, fault}), 32'({V_IDLE, 1'b0}));
      tick();
    end
    run = 1'b1; mem_ready = 1'b1;
    do_instr("after idle", 6'b100101, 1'b0, V_LDI, 1'b0);
    do_instr("run drop", 6'b001000, 1'b0, V_ALU010, 1'b1);
    check_val("held ctrl", 32'(ctrl), 32'(V_IDLE));
    tick();
    check_val("held ctrl 2", 32'(ctrl), 32'(V_IDLE));
    check_val("held retired", 32'(retired), 32'(exp_ret));

    // 6: reset during EXEC
    run = 1'b1;
    tick(); tick();
    check_val("pre-reset exec pc_we", 32'(pc_we), 32'd1);
    reset = 1'b1;
    tick();
    check_val("reset in exec pc_we/we3/wez", 32'({pc_we, we3, wez}), 32'd0);
    check_val("reset in exec retired", 32'(retired), 32'd0);
    check_val("reset in exec fetch", 32'(mem_req), 32'd1);
    reset = 1'b0;
    exp_ret = 4'd0;
    #1;
    // Retired counter wraps after 16 instructions with CNT_W=4
    for (int i = 0; i < 16; i++) do_instr("wrap", 6'b000100, 1'b0, 10'b0_0_1_1_0_1_1_001, 1'b0);
    check_val("retired wrap", 32'(retired), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
